pe_lane_array: RTL and testbench

Parametrised second-generation processing element for the accelerator datapath. It applies one lane-wise operation (pass, multiply, add, multiply-accumulate) across LANES operand pairs. It can iterate with result feedback into either operand, and either returns per-lane results or reduces them through a pipelined adder tree. Unlike the first-generation PE, it has explicit valid/ready handshakes on both sides, an iteration counter, fixed deterministic latency and well-defined reset/clear behaviour.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_reduce_tree.sv | 68 ++++++
 rtl/pe_lane_array.sv | 183 ++++++++++++++++++
 tb/tb_pe_lane_array.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared encodings and helpers for the lane-array processing element.
package pe_pkg;

    // Lane operation select
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MAC  = 2'b11;

    // Result feedback select; 2'b11 is reserved and behaves like FB_NONE
    localparam logic [1:0] FB_NONE = 2'b00;
    localparam logic [1:0] FB_PAR  = 2'b01;
    localparam logic [1:0] FB_IN   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_REDUCE,
        ST_DONE
    } state_e;

    // Number of registered adder levels needed to reduce 'lanes' values
    function automatic int reduce_lat(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/pe_reduce_tree.sv
// Pipelined signed adder tree: one register level per tree level, laid out
// as a binary heap (node i sums children 2i+1 and 2i+2; lane values sit in
// the leaf slots after the LANES-1 internal nodes).
module pe_reduce_tree
    import pe_pkg::*;
#(
    parameter int LANES = 16,
    parameter int DW    = 32,
    localparam int TW   = DW + $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic                vld_in,
    input  logic [LANES*DW-1:0] lanes,
    output logic                vld_out,
    output logic [TW-1:0]       total
);

    localparam int LAT   = reduce_lat(LANES);
    localparam int NODES = LANES - 1;

    logic signed [TW-1:0] node_q [NODES];
    logic signed [TW-1:0] heap   [2*LANES-1];
    logic [LAT-1:0]       vld_p;

    // Heap view: registered internal nodes followed by sign-extended lanes
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            heap[i] = node_q[i];
        end
        for (int j = 0; j < LANES; j++) begin
            heap[NODES+j] = {{(TW-DW){lanes[j*DW+DW-1]}}, lanes[j*DW +: DW]};
        end
    end

    // Every node registers the sum of its two children while enabled; the
    // root is correct after LAT enabled edges with a steady lane input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) node_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NODES; i++) node_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < NODES; i++) begin
                node_q[i] <= heap[2*i+1] + heap[2*i+2];
            end
        end
    end

    // Valid shift pipe; it is launched on the last compute cycle, so its
    // output flags the cycle in which the root loads its final sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else if (clear) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= vld_in;
            for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    assign vld_out = vld_p[LAT-1];
    assign total   = node_q[0];

endmodule

// File: rtl/pe_lane_array.sv
// Lane-wise processing element: applies pass/mul/add/mac across LANES
// operand pairs, iterates with optional result feedback, and returns either
// per-lane results or their reduced sum. One job in flight at a time.
module pe_lane_array
    import pe_pkg::*;
#(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int ITW   = 4,
    localparam int TW   = DW + $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES*DW-1:0] par_data,
    input  logic [1:0]          op,
    input  logic [1:0]          fb_mode,
    input  logic [ITW-1:0]      iter,
    input  logic                out_mode,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_lanes,
    output logic [TW-1:0]       out_total
);

    localparam int PW = 2 * DW;

    state_e               state_q, state_n;
    logic [1:0]           op_q, fb_q;
    logic [ITW-1:0]       iter_q, cnt_q;
    logic                 omode_q;
    logic signed [DW-1:0] a_q    [LANES];
    logic signed [DW-1:0] b_q    [LANES];
    logic signed [DW-1:0] acc_q  [LANES];
    logic signed [DW-1:0] res_q  [LANES];
    logic signed [DW-1:0] lane_r [LANES];
    logic                 accept, last_pass;
    logic                 tree_vld_in, tree_last, tree_en;

    // Keep the low DW bits of a full-width product (two's complement wrap)
    function automatic logic signed [DW-1:0] wrap_dw(input logic signed [PW-1:0] x);
        return x[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] lane_op(
        input logic [1:0]           f,
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b,
        input logic signed [DW-1:0] acc
    );
        logic signed [PW-1:0] prod;
        prod = PW'(a) * PW'(b);
        case (f)
            OP_PASS: lane_op = a;
            OP_MUL:  lane_op = wrap_dw(prod);
            OP_ADD:  lane_op = a + b;
            default: lane_op = acc + wrap_dw(prod);
        endcase
    endfunction

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last_pass = (cnt_q == iter_q);
    assign tree_en   = (state_q == ST_REDUCE);

    // Next-state decode; clear overrides every transition
    always_comb begin
        state_n     = state_q;
        tree_vld_in = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_n = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (last_pass) begin
                    if (omode_q) begin
                        state_n     = ST_REDUCE;
                        tree_vld_in = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_REDUCE: begin
                if (tree_last) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (clear) begin
            state_n     = ST_IDLE;
            tree_vld_in = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_n;
    end

    // Job configuration captured at accept, plus the pass counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            fb_q    <= '0;
            iter_q  <= '0;
            omode_q <= 1'b0;
            cnt_q   <= '0;
        end else if (clear) begin
            op_q    <= '0;
            fb_q    <= '0;
            iter_q  <= '0;
            omode_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_q    <= op;
            fb_q    <= fb_mode;
            iter_q  <= iter;
            omode_q <= out_mode;
            cnt_q   <= '0;
        end else if (state_q == ST_COMPUTE && !last_pass) begin
            cnt_q <= cnt_q + ITW'(1);
        end
    end

    // Per-lane combinational compute and result packing
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_r[g]               = lane_op(op_q, a_q[g], b_q[g], acc_q[g]);
        assign out_lanes[g*DW +: DW]   = res_q[g];
    end

    // Operand, accumulator and result registers for all lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0; b_q[i] <= '0; acc_q[i] <= '0; res_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0; b_q[i] <= '0; acc_q[i] <= '0; res_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i]   <= in_data[i*DW +: DW];
                b_q[i]   <= par_data[i*DW +: DW];
                acc_q[i] <= '0;
            end
        end else if (state_q == ST_COMPUTE) begin
            for (int i = 0; i < LANES; i++) begin
                res_q[i] <= lane_r[i];
                if (op_q == OP_MAC) acc_q[i] <= lane_r[i];
                case (fb_q)
                    FB_PAR:  b_q[i] <= lane_r[i];
                    FB_IN:   a_q[i] <= lane_r[i];
                    FB_NONE: ;
                    default: ;
                endcase
            end
        end
    end

    pe_reduce_tree #(
        .LANES (LANES),
        .DW    (DW)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .en      (tree_en),
        .vld_in  (tree_vld_in),
        .lanes   (out_lanes),
        .vld_out (tree_last),
        .total   (out_total)
    );

endmodule

// File: tb/tb_pe_lane_array.sv
// Directed bench for pe_lane_array with an iterative reference model and a
// per-cycle compare process.
module tb_pe_lane_array;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int ITW   = 4;
    localparam int TW    = DW + $clog2(LANES);
    localparam int LAT   = $clog2(LANES);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data = '0;
    logic [LANES*DW-1:0] par_data = '0;
    logic [1:0]          op = '0;
    logic [1:0]          fb_mode = '0;
    logic [ITW-1:0]      iter = '0;
    logic                out_mode = 1'b0;
    logic                clear = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LANES*DW-1:0] out_lanes;
    logic [TW-1:0]       out_total;

    always #5 clk = ~clk;

    pe_lane_array #(.LANES(LANES), .DW(DW), .ITW(ITW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .par_data  (par_data),
        .op        (op),
        .fb_mode   (fb_mode),
        .iter      (iter),
        .out_mode  (out_mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lanes (out_lanes),
        .out_total (out_total)
    );

    // Driver-owned model state and events
    int     exp_lanes [LANES];
    longint exp_total;
    bit     exp_om;
    int     acc_seq = 0, acc_lat = 0;
    int     end_seq = 0, end_kind = 0;
    int     pin_lane = -1, pin_lval = 0;
    bit     pin_ten = 0;
    longint pin_tval = 0;

    // Compare-owned state
    int     total = 0, bad = 0;
    int     seen_acc = 0, seen_end = 0;
    bit     active = 0, zero_chk = 0, exp_ov = 0;
    int     remain = 0;
    int     mi;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint lane_of(input int i);
        return longint'($signed(out_lanes[i*DW +: DW]));
    endfunction

    // Compare DUT outputs against the model once per cycle
    always @(negedge clk) begin
        if (acc_seq != seen_acc) begin
            seen_acc = acc_seq;
            active   = 1;
            remain   = acc_lat;
        end
        zero_chk = 0;
        if (end_seq != seen_end) begin
            seen_end = end_seq;
            active   = 0;
            zero_chk = (end_kind != 0);
        end
        if (!rst) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_in_ready", longint'(in_ready), 1);
            chk("rst_out_total", longint'($signed(out_total)), 0);
            chk("rst_out_lanes_nonzero", longint'(out_lanes != '0), 0);
        end else begin
            exp_ov = active && (remain == 0);
            chk("in_ready", longint'(in_ready), longint'(!active));
            chk("out_valid", longint'(out_valid), longint'(exp_ov));
            if (zero_chk) begin
                chk("abort_lanes_nonzero", longint'(out_lanes != '0), 0);
                chk("abort_total", longint'($signed(out_total)), 0);
            end
            if (exp_ov && out_valid) begin
                mi = 0;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_of(i) != longint'(exp_lanes[i])) begin
                        mi = i;
                        break;
                    end
                end
                if (!exp_om) chk("lanes", lane_of(mi), longint'(exp_lanes[mi]));
                else         chk("total", longint'($signed(out_total)), exp_total);
                if (pin_lane >= 0) chk("pin_lane", lane_of(pin_lane), longint'(pin_lval));
                if (pin_ten)       chk("pin_total", longint'($signed(out_total)), pin_tval);
            end
            if (active && remain > 0) remain--;
        end
    end

    // Reference: iterate the lane rule pass by pass on plain 32-bit ints
    task automatic model(input logic [1:0] o, input logic [1:0] fb, input int it,
                         input bit om, input int a0, input int as, input int b0, input int bs);
        exp_total = 0;
        exp_om    = om;
        for (int i = 0; i < LANES; i++) begin
            int a, b, acc, r;
            a = a0 + as * i; b = b0 + bs * i; acc = 0; r = 0;
            for (int p = 0; p <= it; p++) begin
                case (o)
                    2'b00:   r = a;
                    2'b01:   r = a * b;
                    2'b10:   r = a + b;
                    default: r = acc + a * b;
                endcase
                if (o == 2'b11) acc = r;
                if (fb == 2'b01)      b = r;
                else if (fb == 2'b10) a = r;
            end
            exp_lanes[i] = r;
            exp_total   += longint'(r);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [1:0] fb, input int it,
                         input bit om, input int a0, input int as, input int b0, input int bs);
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DW +: DW]  = a0 + as * i;
            par_data[i*DW +: DW] = b0 + bs * i;
        end
        op = o; fb_mode = fb; iter = ITW'(it); out_mode = om;
    endtask

    // Offer one job in IDLE; returns at the negedge after the accept edge
    task automatic accept_job(input logic [1:0] o, input logic [1:0] fb, input int it,
                              input bit om, input int a0, input int as, input int b0, input int bs,
                              input int pl, input int plv, input bit pte, input longint ptv,
                              output int lat);
        model(o, fb, it, om, a0, as, b0, bs);
        lat = 1 + it + (om ? LAT : 0);
        @(negedge clk);
        drive(o, fb, it, om, a0, as, b0, bs);
        in_valid = 1'b1;
        @(posedge clk);
        pin_lane = pl; pin_lval = plv; pin_ten = pte; pin_tval = ptv;
        acc_lat  = lat;
        acc_seq++;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {LANES{32'hDEAD_BEEF}};
        par_data = {LANES{32'h1234_5678}};
        op = ~o; fb_mode = ~fb; iter = ~ITW'(it); out_mode = ~om;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        end_kind = 0;
        end_seq++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] o, input logic [1:0] fb, input int it,
                           input bit om, input int a0, input int as, input int b0, input int bs,
                           input int hold, input int pl, input int plv, input bit pte, input longint ptv);
        int lat;
        accept_job(o, fb, it, om, a0, as, b0, bs, pl, plv, pte, ptv, lat);
        repeat (lat) @(negedge clk);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        handshake();
    endtask

    task automatic abort_clear();
        clear = 1'b1;
        @(posedge clk);
        end_kind = 1;
        end_seq++;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // A*B, per-lane results: lane i = 3i
        run_job(2'b01, 2'b00, 0, 1'b0, 0, 1, 3, 0, 0, 5, 15, 1'b0, 0);
        // A+B reduced: sum(i+1) = 136, then all -1 -> -16
        run_job(2'b10, 2'b00, 0, 1'b1, 0, 1, 1, 0, 0, -1, 0, 1'b1, 136);
        run_job(2'b10, 2'b00, 0, 1'b1, -1, 0, 0, 0, 0, -1, 0, 1'b1, -16);
        // Feedback into B, four passes: 2,4,8,16
        run_job(2'b01, 2'b01, 3, 1'b0, 2, 0, 1, 0, 0, 0, 16, 1'b0, 0);
        // Product overflow wraps to 0
        run_job(2'b01, 2'b00, 0, 1'b0, 65536, 0, 65536, 0, 0, 3, 0, 1'b0, 0);
        // Feedback into A, reduced: lane i = 4i, total 480
        run_job(2'b01, 2'b10, 1, 1'b1, 0, 1, 2, 0, 0, -1, 0, 1'b1, 480);
        // Reserved feedback code behaves as none: 3*2 = 6
        run_job(2'b01, 2'b11, 2, 1'b0, 3, 0, 2, 0, 0, 9, 6, 1'b0, 0);
        // Backpressure in DONE for 5 cycles with a stray in_valid pulse
        run_job(2'b10, 2'b00, 0, 1'b0, 0, 1, 10, 0, 5, 15, 25, 1'b0, 0);

        // Abort mid-COMPUTE, then a MAC job that must not see old state
        accept_job(2'b11, 2'b01, 7, 1'b0, 1, 1, 2, 0, -1, 0, 1'b0, 0, lat);
        repeat (2) @(negedge clk);
        abort_clear();
        run_job(2'b11, 2'b00, 2, 1'b0, 5, 0, 7, 0, 0, 7, 105, 1'b0, 0);

        // clear coincident with an offered job: nothing is taken
        drive(2'b10, 2'b00, 0, 1'b0, 9, 0, 9, 0);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        run_job(2'b10, 2'b00, 0, 1'b0, 0, 1, 0, 1, 0, 6, 12, 1'b0, 0);

        // Reset asserted while reducing, then a fresh reduced job
        accept_job(2'b10, 2'b00, 0, 1'b1, 0, 1, 1, 0, -1, 0, 1'b0, 0, lat);
        @(posedge clk);
        #2 rst = 1'b0;
        end_kind = 1;
        end_seq++;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        run_job(2'b10, 2'b00, 0, 1'b1, 0, 1, 1, 0, 0, -1, 0, 1'b1, 136);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
